// File: rtl/kbc.sv
// kbc: 8042-style keyboard controller. Buffers PS/2 scancodes in a FIFO,
// exposes data on PORT_DATA and status/commands on PORT_STAT, and raises
// a level IRQ1 while a byte is waiting.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | normal operation; data-port writes are ignored
// WCMD  | a 60h command was issued; the next data write sets cmd_byte
`timescale 1ns/1ps
module kbc #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] PORT_DATA = 16'h0060,
  parameter logic [15:0] PORT_STAT = 16'h0064
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_done,
  input  logic [15:0] port_a,
  input  logic        port_r,
  input  logic        port_w,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WCMD} state_t;

  state_t        state;
  logic          r_prev, w_prev;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf, kb_en, reply_v;
  logic [7:0]    cmd_byte, reply, last;

  logic empty, full, obf;
  logic r_edge, w_edge;
  logic rd_data, rd_stat, wr_data, wr_stat;
  logic push_req, push, pop, ovf_set;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign obf   = reply_v | ~empty;
  assign irq   = cmd_byte[0] & obf;

  assign r_edge  = port_r & ~r_prev;
  assign w_edge  = port_w & ~w_prev;
  assign rd_data = r_edge & (port_a == PORT_DATA);
  assign rd_stat = r_edge & (port_a == PORT_STAT);
  assign wr_data = w_edge & (port_a == PORT_DATA);
  assign wr_stat = w_edge & (port_a == PORT_STAT);

  // A pending reply is served ahead of the FIFO, so it shields the head byte.
  assign pop      = rd_data & ~reply_v & ~empty;
  assign push_req = ps2_done & kb_en;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  // Read mux: reply first, then FIFO head, then the last byte delivered.
  always_comb begin
    port_i = 8'h00;
    if (port_a == PORT_DATA) begin
      if (reply_v)     port_i = reply;
      else if (!empty) port_i = mem[rd_ptr];
      else             port_i = last;
    end else if (port_a == PORT_STAT) begin
      port_i = {2'b00, ovf, kb_en, 1'b0, 1'b1, 1'b0, obf};
    end
  end

  // Previous request levels for once-per-assertion edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
      w_prev <= 1'b0;
    end else begin
      r_prev <= port_r;
      w_prev <= port_w;
    end
  end

  // FIFO storage; contents are meaningless outside the count window.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ps2_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Command FSM with status, reply and last-byte registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ovf      <= 1'b0;
      kb_en    <= 1'b1;
      cmd_byte <= 8'h01;
      reply    <= 8'h00;
      reply_v  <= 1'b0;
      last     <= 8'h00;
    end else begin
      if (rd_data) begin
        if (reply_v) begin
          reply_v <= 1'b0;
          last    <= reply;
        end else if (!empty) begin
          last <= mem[rd_ptr];
        end
      end

      // Overflow detected in the same cycle as a status read stays visible.
      if (ovf_set)      ovf <= 1'b1;
      else if (rd_stat) ovf <= 1'b0;

      if (wr_stat) begin
        case (port_o)
          8'hAD: kb_en <= 1'b0;
          8'hAE: kb_en <= 1'b1;
          8'h20: begin
            reply   <= cmd_byte;
            reply_v <= 1'b1;
          end
          default: ;
        endcase
        state <= (port_o == 8'h60) ? WCMD : IDLE;
      end else if (wr_data && state == WCMD) begin
        cmd_byte <= port_o;
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_kbc.sv
// tb_kbc: directed and random checks of kbc against a queue-based model.
`timescale 1ns/1ps
module tb_kbc;
  localparam int          DEPTH = 16;
  localparam logic [15:0] PD    = 16'h0060;
  localparam logic [15:0] PS    = 16'h0064;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  ps2_data = 8'h00;
  logic        ps2_done = 1'b0;
  logic [15:0] port_a = 16'h0000;
  logic        port_r = 1'b0;
  logic        port_w = 1'b0;
  logic [7:0]  port_o = 8'h00;
  logic [7:0]  port_i;
  logic        irq;

  kbc #(.DEPTH(DEPTH), .PORT_DATA(PD), .PORT_STAT(PS)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_data(ps2_data), .ps2_done(ps2_done),
    .port_a(port_a), .port_r(port_r), .port_w(port_w), .port_o(port_o),
    .port_i(port_i), .irq(irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the controller's visible state.
  logic [7:0] q[$];
  bit         m_ovf, m_kb_en, m_reply_v, m_wcmd;
  logic [7:0] m_reply, m_last, m_cmd;

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_kb_en = 1; m_reply_v = 0; m_wcmd = 0;
    m_reply = 8'h00; m_last = 8'h00; m_cmd = 8'h01;
  endfunction

  function automatic bit m_obf();
    return m_reply_v || (q.size() != 0);
  endfunction

  function automatic logic [7:0] m_stat();
    logic [7:0] s;
    s = 8'h04;
    if (m_ovf)   s = s + 8'h20;
    if (m_kb_en) s = s + 8'h10;
    if (m_obf()) s = s + 8'h01;
    return s;
  endfunction

  // Returns what a read shows, then applies the read's side effects.
  function automatic logic [7:0] m_read(logic [15:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == PD) begin
      if (m_reply_v) begin v = m_reply; m_reply_v = 0; m_last = v; end
      else if (q.size() != 0) begin v = q.pop_front(); m_last = v; end
      else v = m_last;
    end else if (a == PS) begin
      v = m_stat();
      m_ovf = 0;
    end
    return v;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(string tag);
    #1;
    check(tag, {7'b0, irq}, {7'b0, m_cmd[0] & m_obf()});
  endtask

  task automatic push(logic [7:0] b);
    @(negedge clock);
    ps2_data = b; ps2_done = 1'b1;
    @(negedge clock);
    ps2_done = 1'b0;
    if (m_kb_en) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1;
    end
  endtask

  task automatic rd(logic [15:0] a, string tag, int hold = 1);
    logic [7:0] exp;
    @(negedge clock);
    port_a = a; port_r = 1'b1;
    #1;
    exp = m_read(a);
    check(tag, port_i, exp);
    repeat (hold) @(negedge clock);
    port_r = 1'b0;
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] v);
    @(negedge clock);
    port_a = a; port_o = v; port_w = 1'b1;
    @(negedge clock);
    port_w = 1'b0;
    if (a == PS) begin
      if (v == 8'hAD) m_kb_en = 0;
      if (v == 8'hAE) m_kb_en = 1;
      if (v == 8'h20) begin m_reply = m_cmd; m_reply_v = 1; end
      m_wcmd = (v == 8'h60);
    end else if (a == PD && m_wcmd) begin
      m_cmd = v; m_wcmd = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    port_a = PS;
    model_reset();
    #1;
    check("reset_stat_async", port_i, 8'h14);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp;
    int op;

    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Reset values
    rd(PS, "reset_stat");
    rd(PD, "reset_data");
    chk_irq("reset_irq");

    // Ordered delivery and irq release
    push(8'h1C); push(8'hF0); push(8'h1C);
    chk_irq("irq_after_push");
    rd(PD, "seq0"); rd(PD, "seq1"); rd(PD, "seq2");
    chk_irq("irq_after_drain");
    rd(PD, "seq_last");

    // Overflow with 17 pushes
    for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
    rd(PS, "ovf_set");
    for (int i = 0; i < DEPTH; i++) rd(PD, "ovf_drain");
    rd(PS, "ovf_clear");

    // Held read pops once
    push(8'h33); push(8'h44);
    rd(PD, "hold_first", 5);
    rd(PD, "hold_second");
    chk_irq("hold_irq");

    // cmd_byte write disables irq, 20 returns cmd_byte ahead of the FIFO
    wr(PS, 8'h60); wr(PD, 8'h00);
    push(8'h2A);
    rd(PS, "cmd_obf");
    chk_irq("cmd_irq_off");
    wr(PS, 8'h20);
    rd(PD, "cmd_reply");
    rd(PD, "cmd_fifo");
    wr(PS, 8'h60); wr(PD, 8'h01);

    // Keyboard disable / enable
    wr(PS, 8'hAD);
    push(8'h45);
    rd(PS, "kb_dis_stat");
    wr(PS, 8'hAE);
    push(8'h45);
    rd(PD, "kb_en_data");

    // Simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    b = 8'($urandom);
    @(negedge clock);
    port_a = PD; port_r = 1'b1; ps2_data = b; ps2_done = 1'b1;
    #1;
    exp = m_read(PD);
    q.push_back(b);
    check("full_pushpop", port_i, exp);
    @(negedge clock);
    port_r = 1'b0; ps2_done = 1'b0;
    rd(PS, "full_pushpop_stat");
    for (int i = 0; i < DEPTH; i++) rd(PD, "full_pushpop_drain");
    rd(PS, "full_pushpop_empty");

    // Reset mid-operation drops FIFO and reply
    push(8'h11); push(8'h22); wr(PS, 8'h20);
    do_reset();
    rd(PS, "midreset_stat");
    rd(PD, "midreset_data");
    chk_irq("midreset_irq");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: push(8'($urandom));
        4, 5, 6:    rd(PD, "rnd_data", $urandom_range(1, 3));
        7:          rd(PS, "rnd_stat", $urandom_range(1, 2));
        8: begin
          case ($urandom_range(0, 5))
            0:       wr(PS, 8'hAD);
            1, 2:    wr(PS, 8'hAE);
            3:       wr(PS, 8'h20);
            4:       wr(PS, 8'h60);
            default: wr(PS, 8'($urandom));
          endcase
        end
        9:  wr(PD, 8'($urandom));
        10: rd(16'h0061, "rnd_other");
        default: chk_irq("rnd_irq");
      endcase
      if (op < 4) chk_irq("rnd_push_irq");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kbc.md
# kbc

Keyboard controller between the PS/2 receiver and the CPU port bus. It queues scancode bytes from the receiver in a FIFO and presents them on I/O port 60h, with an 8042-style status register on port 64h. It decodes a small 8042 command subset and drives a level interrupt request toward the interrupt controller while data is waiting. It occupies the empty keyboard slot of the DE0 top, fed by `ps2` and consumed by `core` through `port_a/port_r/port_w/port_i/port_o`.

## Interface

- `DEPTH`, 16: FIFO depth in bytes. Must be a power of two, at least 2.
- `PORT_DATA`, 16'h0060: data port address.
- `PORT_STAT`, 16'h0064: status/command port address.

- `clock`  in  1  system clock (clock_25 domain).
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ps2_data`  in  8  received byte from the PS/2 receiver.
- `ps2_done`  in  1  one-cycle strobe; `ps2_data` is valid in that cycle.
- `port_a`  in  16  CPU port address.
- `port_r`  in  1  CPU port read request (level; may be held several cycles).
- `port_w`  in  1  CPU port write request (level; may be held several cycles).
- `port_o`  in  8  CPU write data.
- `port_i`  out  8  CPU read data (combinational from registers).
- `irq`  out  1  level interrupt request (IRQ1).

## Operation

- Read and write requests are rising-edge detected with internal `r_prev`/`w_prev` registers. A read or write acts once per assertion, no matter how long it is held.
- FIFO push: a `ps2_done` with the keyboard enabled writes `ps2_data` at the tail.
  - While the keyboard is disabled, the byte is discarded silently.
  - While the FIFO is full, the byte is discarded and sticky `ovf` is set.
- Output-buffer-full: `obf = reply_v | ~empty`.
- Read of `PORT_DATA`:
  - If `reply_v` is set, `port_i` = `reply`. The edge clears `reply_v` and loads `last` with `reply`.
  - Otherwise, if the FIFO is non-empty, `port_i` = head byte. The edge pops the FIFO and loads `last` with that byte.
  - Otherwise `port_i` = `last`, with no state change.
- Read of `PORT_STAT`: `port_i` = {1'b0, 1'b0, ovf, kb_en, 1'b0, 1'b1, 1'b0, obf}. The read edge clears `ovf`.
- Read of any other address: `port_i` = 8'h00.
- Write of `PORT_STAT` is a command:
  - AD: `kb_en`=0.
  - AE: `kb_en`=1.
  - 20: `reply`=`cmd_byte`, `reply_v`=1.
  - 60: the state machine moves to WCMD.
  - All other values are ignored.
- Write of `PORT_DATA`:
  - In WCMD: `cmd_byte`=`port_o`, and the state returns to IDLE.
  - In IDLE: the write is ignored.
- State machine: IDLE, WCMD.
  - Any `PORT_STAT` write while in WCMD executes as a new command. If it is not 60, it also returns the state to IDLE.
- `irq = cmd_byte[0] & obf`.

## Timing

- Reset values:
  - FIFO empty (read/write pointers 0, count 0).
  - `ovf`=0, `kb_en`=1, `cmd_byte`=8'h01.
  - `reply`=8'h00, `reply_v`=0, `last`=8'h00.
  - State IDLE, `r_prev`=`w_prev`=0.
  - Outputs: `irq`=0; `port_i` reads 8'h14 at `PORT_STAT` and 8'h00 at `PORT_DATA`.
- Reset asserted mid-operation discards the FIFO contents and any pending reply immediately.
- Push latency: byte strobed in cycle N is readable, `obf`=1 and `irq`=1 from cycle N+1.
- Pop takes effect at the clock edge that ends the first cycle of `port_r` high. The next byte (or `last`) appears in the following cycle.
- A push and a pop in the same cycle:
  - FIFO full: both occur, count unchanged, `ovf` not set.
  - FIFO empty: the pop is a no-op and the push lands.
- Pointers wrap modulo `DEPTH`. Count is `clog2(DEPTH)+1` bits wide.
- A pending `reply` does not block pushes. FIFO contents are preserved behind it.
- `irq` deasserts in the cycle after the read edge that empties the last byte.

## Test plan

- Reset → status read 8'h14, data read 8'h00, `irq`=0.
- Push 1C, F0, 1C; read 60h three times → 1C, F0, 1C in order. `irq` drops after the third read. A fourth read returns 1C.
- Push 17 bytes with `DEPTH`=16 → status bit5=1, and 16 bytes read back. A second status read shows bit5=0.
- Hold `port_r` on 60h for 5 cycles with 2 bytes queued → exactly one pop. The second byte remains readable.
- Write 64h←60, then 60h←00, then push 2A → `obf`=1, `irq`=0. Write 64h←20 → 60h read returns 00, then a further read returns 2A.
- Write 64h←AD, push 45 → FIFO stays empty and status bit4=0. Write AE, push 45 → 45 readable. Also push while full and pop in the same cycle → count stays 16, no overflow.
